msg_sched_gen: RTL and testbench

MSG_SCHED_GEN -- requirements
Module: msg_sched_gen

---
 rtl/msg_sched_gen.sv | 100 ++++++++++
 tb/tb_msg_sched_gen.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_sched_gen.sv
// Message schedule generator for SHA-256 / SHA-512.
// Accepts one 16-word message block, then streams schedule words W[0..ROUNDS-1]
// over a valid/ready handshake using a sliding 16-word window.
//
//   state | meaning
//   IDLE  | waiting for a message block (blk_ready=1)
//   RUN   | streaming schedule words (w_valid=1, busy=1)
module msg_sched_gen #(
  parameter int SHA512 = 0,
  localparam int W = (SHA512 != 0) ? 64 : 32,
  localparam int ROUNDS = (SHA512 != 0) ? 80 : 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            blk_valid,
  output logic            blk_ready,
  input  logic [16*W-1:0] blk,
  output logic            w_valid,
  input  logic            w_ready,
  output logic [W-1:0]    w_data,
  output logic [6:0]      w_idx,
  output logic            w_last,
  output logic            busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [6:0] T_LAST = 7'(ROUNDS - 1);

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   m [16];
  logic [6:0]     t;
  logic [W-1:0]   w_new;
  logic           xfer;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [W-1:0] sig0(input logic [W-1:0] x);
    if (SHA512 != 0) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else             return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [W-1:0] sig1(input logic [W-1:0] x);
    if (SHA512 != 0) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else             return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign xfer      = (state == RUN) && w_ready;
  assign w_new     = m[0] + sig0(m[1]) + m[9] + sig1(m[14]);
  assign blk_ready = (state == IDLE);
  assign w_valid   = (state == RUN);
  assign busy      = (state == RUN);
  assign w_data    = m[0];
  assign w_idx     = t;
  assign w_last    = (state == RUN) && (t == T_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort wins over load and transfer.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (blk_valid) state_nxt = RUN;
        RUN:     if (w_ready && (t == T_LAST)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Window and round index: load on accept, shift and extend on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
      for (int k = 0; k < 16; k++) m[k] <= '0;
    end else if (abort) begin
      t <= '0;
    end else if (state == IDLE) begin
      if (blk_valid) begin
        t <= '0;
        for (int k = 0; k < 16; k++) m[k] <= blk[16*W-1-k*W -: W];
      end
    end else if (xfer) begin
      for (int k = 0; k < 15; k++) m[k] <= m[k+1];
      m[15] <= w_new;
      t     <= (t == T_LAST) ? '0 : t + 7'd1;
    end
  end

endmodule

// File: tb/tb_msg_sched_gen.sv
// Scoreboard bench for msg_sched_gen: a SHA-256 instance driven with random
// blocks and handshake patterns, plus a SHA-512 instance run on the "abc" block.
module tb_msg_sched_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, abort, blk_valid, w_ready;
  logic [511:0] blk;
  logic         blk_ready, w_valid, w_last, busy;
  logic [31:0]  w_data;
  logic [6:0]   w_idx;

  logic          abort5, blk_valid5, w_ready5;
  logic [1023:0] blk5;
  logic          blk_ready5, w_valid5, w_last5, busy5;
  logic [63:0]   w_data5;
  logic [6:0]    w_idx5;

  msg_sched_gen #(.SHA512(0)) dut (
    .clk(clk), .rst(rst), .abort(abort), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk(blk), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
    .w_last(w_last), .busy(busy)
  );

  msg_sched_gen #(.SHA512(1)) dut512 (
    .clk(clk), .rst(rst), .abort(abort5), .blk_valid(blk_valid5), .blk_ready(blk_ready5),
    .blk(blk5), .w_valid(w_valid5), .w_ready(w_ready5), .w_data(w_data5), .w_idx(w_idx5),
    .w_last(w_last5), .busy(busy5)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] d;
    int          idx;
    bit          last;
  } exp_t;

  exp_t        q[$];
  logic [63:0] bw[16];
  logic [63:0] ms[80];
  logic [63:0] cap[64];
  bit          started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: textbook schedule recurrence on full arrays.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit b512);
    logic [31:0] y;
    if (b512) return (x >> n) | (x << (64 - n));
    y = x[31:0];
    y = (y >> n) | (y << (32 - n));
    return {32'b0, y};
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input bit b512);
    if (b512) return rotr(x, 1, 1) ^ rotr(x, 8, 1) ^ (x >> 7);
    return rotr(x, 7, 0) ^ rotr(x, 18, 0) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input bit b512);
    if (b512) return rotr(x, 19, 1) ^ rotr(x, 61, 1) ^ (x >> 6);
    return rotr(x, 17, 0) ^ rotr(x, 19, 0) ^ (x >> 10);
  endfunction

  function automatic void build(input bit b512);
    logic [63:0] mask;
    mask = b512 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int i = 0; i < 16; i++) ms[i] = bw[i] & mask;
    for (int i = 16; i < 80; i++)
      ms[i] = (sig1(ms[i-2], b512) + ms[i-7] + sig0(ms[i-15], b512) + ms[i-16]) & mask;
  endfunction

  // Monitor: compare every presented word against the scoreboard head.
  always @(negedge clk) begin
    if (started) begin
      chk("blk_ready_vs_valid", blk_ready, !w_valid);
      chk("busy_vs_valid", busy, w_valid);
      if (w_valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got idx %0d data %h expected no word", w_idx, w_data);
        end else begin
          chk("w_data", w_data, q[0].d);
          chk("w_idx", w_idx, q[0].idx);
          chk("w_last", w_last, q[0].last);
          if (w_ready) begin
            cap[w_idx[5:0]] = w_data;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic rand_block();
    for (int k = 0; k < 16; k++) bw[k] = {32'b0, $urandom};
  endtask

  // Present the block in bw to the SHA-256 instance and queue its 64 words.
  task automatic load();
    int n;
    n = 0;
    while (!blk_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!blk_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: got blk_ready %0b expected 1", blk_ready);
    end
    build(0);
    for (int k = 0; k < 16; k++) blk[511-32*k -: 32] = bw[k][31:0];
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    for (int i = 0; i < 64; i++) q.push_back('{d: ms[i], idx: i, last: (i == 63)});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_w_valid"}, w_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_blk_ready"}, blk_ready, 1'b1);
    chk({tag, "_w_last"}, w_last, 1'b0);
    chk({tag, "_w_idx"}, w_idx, 7'd0);
  endtask

  // Drive w_ready until the scoreboard drains, optionally stalling, aborting,
  // resetting at a given index, or spamming blk_valid during the run.
  task automatic drain(input bit rnd, input int stall_at, input int abort_at,
                       input int rst_at, input bit ign);
    int stall_left;
    bit stall_done;
    stall_left = 0;
    stall_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (q.size() == 0) begin
        blk_valid = 1'b0;
        return;
      end
      if (abort_at >= 0 && w_valid && w_idx == 7'(abort_at)) begin
        blk_valid = 1'b0;
        abort = 1'b1;
        w_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        @(negedge clk);
        check_idle_outputs("abort");
        @(posedge clk); #1;
        return;
      end
      if (rst_at >= 0 && w_valid && w_idx == 7'(rst_at)) begin
        blk_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check_idle_outputs("reset_mid");
        chk("reset_mid_w_data", w_data, 32'd0);
        @(posedge clk); #1;
        return;
      end
      if (stall_at >= 0 && !stall_done && w_valid && w_idx == 7'(stall_at)) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        w_ready = 1'b0;
        stall_left--;
      end else begin
        w_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (ign && w_valid && w_idx < 7'd60) begin
        blk_valid = 1'b1;
        for (int k = 0; k < 16; k++) blk[511-32*k -: 32] = $urandom;
      end else begin
        blk_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    blk_valid = 1'b0;
    vectors++;
    miscompares++;
    $display("FAIL drain_timeout: got %0d words pending expected 0", q.size());
  endtask

  initial begin
    int cnt;
    rst = 1'b1; abort = 1'b0; blk_valid = 1'b0; w_ready = 1'b0; blk = '0;
    abort5 = 1'b0; blk_valid5 = 1'b0; w_ready5 = 1'b0; blk5 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    chk("reset_w_data", w_data, 32'd0);
    chk("reset512_busy", busy5, 1'b0);
    chk("reset512_blk_ready", blk_ready5, 1'b1);
    @(posedge clk); #1;

    // "abc" block, consumer always ready
    for (int k = 0; k < 16; k++) bw[k] = '0;
    bw[0] = 64'h6162_6380;
    bw[15] = 64'h18;
    load();
    drain(0, -1, -1, -1, 0);
    chk("abc_w0", cap[0], 32'h6162_6380);
    chk("abc_w16", cap[16], 32'h6162_6380);
    chk("abc_w17", cap[17], 32'h000F_0000);
    @(negedge clk);
    chk("abc_ready_after_last", blk_ready, 1'b1);
    @(posedge clk); #1;

    // five-cycle stall at t=20
    rand_block();
    load();
    drain(0, 20, -1, -1, 0);

    // random blocks with random backpressure
    for (int b = 0; b < 3; b++) begin
      rand_block();
      load();
      drain(1, -1, -1, -1, 0);
    end

    // abort at t=30, then a fresh block
    rand_block();
    load();
    drain(0, -1, 30, -1, 0);
    rand_block();
    load();
    drain(1, -1, -1, -1, 0);

    // blk_valid during RUN must be ignored
    rand_block();
    load();
    drain(1, -1, -1, -1, 1);

    // reset at t=40, then a fresh block
    rand_block();
    load();
    drain(0, -1, -1, 40, 0);
    rand_block();
    load();
    drain(1, -1, -1, -1, 0);

    // SHA-512 "abc" block
    for (int k = 0; k < 16; k++) bw[k] = '0;
    bw[0] = 64'h6162_6380_0000_0000;
    bw[15] = 64'h18;
    build(1);
    for (int k = 0; k < 16; k++) blk5[1023-64*k -: 64] = bw[k];
    blk_valid5 = 1'b1;
    @(posedge clk); #1;
    blk_valid5 = 1'b0;
    w_ready5 = 1'b1;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (w_valid5) begin
        chk("w512_data", w_data5, ms[cnt % 80]);
        chk("w512_idx", w_idx5, cnt);
        chk("w512_last", w_last5, (cnt == 79));
        if (cnt == 16) chk("abc512_w16", w_data5, 64'h6162_6380_0000_0000);
        if (cnt == 17) chk("abc512_w17", w_data5, 64'h0003_0000_0000_00C0);
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
    end
    chk("w512_count", cnt, 80);
    chk("w512_ready_after_last", blk_ready5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
